// File: rtl/fifo_pkg.sv
// Shared FIFO constants and sizing helpers, common to the sync FIFO and
// future async FIFO work.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Two-port synchronous RAM: port A write-only, port B read-only into a
// registered output. The array is not reset; only the output register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
  end

  // Output holds its last value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    b_data <= '0;
    else if (b_re) b_data <= mem[b_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, occupancy flags and error pulses
// around a two-port RAM with one-cycle read latency.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int AFULL_TH  = 6,
  parameter  int AEMPTY_TH = 2,
  localparam int ADDR_W    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0] wp, rp;
  logic             push_ok, pop_ok;
  logic [1:0]       vld_pipe;

  // Flags depend only on registered pointers, never on wr_en/rd_en.
  assign empty        = (wp == rp);
  assign full         = (wp[ADDR_W] != rp[ADDR_W]) &&
                        (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
  assign count        = wp - rp;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  assign push_ok = wr_en && !full;
  assign pop_ok  = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  assign vld_pipe[0] = pop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end

  assign rd_valid = vld_pipe[1];

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_we   (push_ok),
    .a_addr (wp[ADDR_W-1:0]),
    .a_data (wr_data),
    .b_re   (pop_ok),
    .b_addr (rp[ADDR_W-1:0]),
    .b_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed pushes/pops queue expected pop
// data; a negedge monitor compares every rd_valid word against the queue.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_spurious: got rd_valid with data 0x%0h expected no output", rd_data);
      end else begin
        chk("sb_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock: drive inputs after a negedge, return at the next negedge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic pop_exp(input logic [7:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 8'h00);
    rst_n = 1'b1;

    // Fill
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == 4) chk("afull_after5", int'(almost_full), 0);
      if (i == 5) chk("afull_after6", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    cyc(1'b1, 8'h18, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 8);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", int'(overflow), 0);

    // Drain
    for (int i = 0; i < 8; i++) pop_exp(8'h10 + 8'(i));
    chk("drain_empty", int'(empty), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("udf_pulse", int'(underflow), 1);
    chk("udf_rd_valid", int'(rd_valid), 0);
    chk("udf_rd_data_hold", int'(rd_data), 8'h17);
    cyc(1'b0, 8'h00, 1'b0);
    chk("udf_clear", int'(underflow), 0);

    // Simultaneous push/pop at count 4
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
    exp_q.push_back(8'h20);
    cyc(1'b1, 8'hA5, 1'b1);
    chk("sim_count", int'(count), 4);
    pop_exp(8'h21); pop_exp(8'h22); pop_exp(8'h23); pop_exp(8'hA5);
    chk("sim_empty", int'(empty), 1);
    // Simultaneous at empty: push only
    cyc(1'b1, 8'h5A, 1'b1);
    chk("sim_e_count", int'(count), 1);
    chk("sim_e_udf", int'(underflow), 1);
    chk("sim_e_rd_valid", int'(rd_valid), 0);
    pop_exp(8'h5A);

    // Wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      pop_exp(8'(i));
    end
    chk("wrap_empty", int'(empty), 1);

    // Reset mid-operation with a pop in flight
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("mid_count5", int'(count), 5);
    exp_q.push_back(8'h30);
    rd_en = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("mid_empty", int'(empty), 1);
    chk("mid_count", int'(count), 0);
    chk("mid_rd_valid", int'(rd_valid), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'hC3, 1'b0);
    pop_exp(8'hC3);
    chk("post_rst_data", int'(rd_data), 8'hC3);
    cyc(1'b0, 8'h00, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
